matrix_output_writer: RTL and testbench

- Downstream stage of matrixMult. It captures each row result (outputData/outputAddr/outputWrEn) into a BATCH_SIZE-deep row buffer.
- Each element is requantized on capture: arithmetic shift, then signed saturation to RESULT_WIDTH.
- Once all BATCH_SIZE rows are present, the rows are drained in address order over a valid/ready stream to the next memory or DMA stage.
- matrixMult cannot be back-pressured, so this block is always ready to capture while filling and flags writes it must drop.

---
 rtl/matrix_output_writer_if.sv | 29 ++
 rtl/matrix_output_writer.sv | 126 ++++++++++++
 tb/tb_matrix_output_writer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_output_writer_if.sv
// Bus between matrixMult's row output, the requantizing batch writer and its downstream consumer.
// Carries the capture strobe/row, the valid/ready result stream and the status flags.
interface matrix_output_writer_if #(
    parameter int LOG_BATCH_SIZE  = 3,
    parameter int OUTPUT_FEATURES = 8,
    parameter int OUTPUT_WIDTH    = 16,
    parameter int RESULT_WIDTH    = 8
);
    logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] outputData;
    logic [LOG_BATCH_SIZE-1:0]               outputAddr;
    logic                                    outputWrEn;
    logic [OUTPUT_FEATURES*RESULT_WIDTH-1:0] resultData;
    logic [LOG_BATCH_SIZE-1:0]               resultAddr;
    logic                                    resultValid;
    logic                                    resultReady;
    logic                                    batchDone;
    logic                                    dropErr;
    logic [15:0]                             satCount;

    modport slave (
        input  outputData, outputAddr, outputWrEn, resultReady,
        output resultData, resultAddr, resultValid, batchDone, dropErr, satCount
    );

    modport master (
        output outputData, outputAddr, outputWrEn, resultReady,
        input  resultData, resultAddr, resultValid, batchDone, dropErr, satCount
    );
endinterface

// File: rtl/matrix_output_writer.sv
// Requantizes matrixMult rows into a batch buffer, then drains the batch in address order.
// Define MATRIX_OUT_RELU_EN to clamp negative shifted values to zero before saturation.
module matrix_output_writer #(
    parameter int BATCH_SIZE      = 8,
    parameter int LOG_BATCH_SIZE  = 3,
    parameter int OUTPUT_FEATURES = 8,
    parameter int OUTPUT_WIDTH    = 16,
    parameter int RESULT_WIDTH    = 8,
    parameter int SHIFT           = 4
) (
    input logic                   clk,
    input logic                   rst,
    matrix_output_writer_if.slave bus
);
    typedef enum logic {FILL, DRAIN} state_e;
    typedef logic [OUTPUT_FEATURES*RESULT_WIDTH-1:0] row_t;

    localparam int CNT_W = $clog2(OUTPUT_FEATURES + 1);
    localparam logic signed [OUTPUT_WIDTH-1:0] RMAX = OUTPUT_WIDTH'((2 ** (RESULT_WIDTH - 1)) - 1);
    localparam logic signed [OUTPUT_WIDTH-1:0] RMIN = ~RMAX;
    localparam logic [LOG_BATCH_SIZE-1:0]      LAST = LOG_BATCH_SIZE'(BATCH_SIZE - 1);

    // Returns {saturated, value}; the shift floors because it is arithmetic.
    function automatic logic [RESULT_WIDTH:0] requant(input logic signed [OUTPUT_WIDTH-1:0] x);
        logic signed [OUTPUT_WIDTH-1:0] s;
        s = x >>> SHIFT;
`ifdef MATRIX_OUT_RELU_EN
        if (s[OUTPUT_WIDTH-1]) s = '0;
`endif
        if (s > RMAX) return {1'b1, RMAX[RESULT_WIDTH-1:0]};
        if (s < RMIN) return {1'b1, RMIN[RESULT_WIDTH-1:0]};
        return {1'b0, s[RESULT_WIDTH-1:0]};
    endfunction

    state_e                    state_q, state_d;
    logic [BATCH_SIZE-1:0]     row_valid_q, row_valid_d;
    logic [LOG_BATCH_SIZE-1:0] ptr_q, ptr_d;
    logic                      batch_done_q, batch_done_d;
    logic                      drop_err_q, drop_err_d;
    logic [15:0]               sat_cnt_q, sat_cnt_d;
    row_t                      buf_q [BATCH_SIZE];

    logic [RESULT_WIDTH:0]     elem_rq [OUTPUT_FEATURES];
    row_t                      q_row;
    logic [CNT_W-1:0]          sat_num;
    logic [16:0]               sat_sum;
    logic                      wr_fill, accept, last_accept;

    always_comb begin
        q_row   = '0;
        sat_num = '0;
        for (int i = 0; i < OUTPUT_FEATURES; i++) begin
            elem_rq[i] = requant(bus.outputData[i*OUTPUT_WIDTH +: OUTPUT_WIDTH]);
            q_row[i*RESULT_WIDTH +: RESULT_WIDTH] = elem_rq[i][RESULT_WIDTH-1:0];
            sat_num = sat_num + CNT_W'(elem_rq[i][RESULT_WIDTH]);
        end
    end

    assign sat_sum     = {1'b0, sat_cnt_q} + 17'(sat_num);
    assign wr_fill     = bus.outputWrEn && (state_q == FILL);
    assign accept      = (state_q == DRAIN) && bus.resultReady;
    assign last_accept = accept && (ptr_q == LAST);

    // A write landing in DRAIN, including the final-acceptance cycle, is dropped and flagged.
    always_comb begin
        state_d      = state_q;
        row_valid_d  = row_valid_q;
        ptr_d        = ptr_q;
        sat_cnt_d    = sat_cnt_q;
        batch_done_d = last_accept;
        drop_err_d   = drop_err_q | (bus.outputWrEn && (state_q == DRAIN));
        case (state_q)
            FILL: begin
                if (bus.outputWrEn) begin
                    row_valid_d = row_valid_q | (BATCH_SIZE'(1) << bus.outputAddr);
                    sat_cnt_d   = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
                    if (&row_valid_d) begin
                        state_d = DRAIN;
                        ptr_d   = '0;
                    end
                end
            end
            DRAIN: begin
                if (accept) begin
                    ptr_d = ptr_q + 1'b1;
                    if (last_accept) begin
                        state_d     = FILL;
                        row_valid_d = '0;
                        ptr_d       = '0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            row_valid_q  <= '0;
            ptr_q        <= '0;
            batch_done_q <= 1'b0;
            drop_err_q   <= 1'b0;
            sat_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            row_valid_q  <= row_valid_d;
            ptr_q        <= ptr_d;
            batch_done_q <= batch_done_d;
            drop_err_q   <= drop_err_d;
            sat_cnt_q    <= sat_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fill) buf_q[bus.outputAddr] <= q_row;
    end

    // Data and address are gated so they read zero outside a drain.
    assign bus.resultValid = (state_q == DRAIN);
    assign bus.resultAddr  = (state_q == DRAIN) ? ptr_q : '0;
    assign bus.resultData  = (state_q == DRAIN) ? buf_q[ptr_q] : '0;
    assign bus.batchDone   = batch_done_q;
    assign bus.dropErr     = drop_err_q;
    assign bus.satCount    = sat_cnt_q;
endmodule

// File: tb/tb_matrix_output_writer.sv
// Randomized bench for matrix_output_writer against a transaction-level batch model.
module tb_matrix_output_writer;
    localparam int BS = 8;
    localparam int OF = 8;
    localparam int OW = 16;
    localparam int RW = 8;
    localparam int SH = 4;

    typedef int q_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_output_writer_if bus_if ();
    matrix_output_writer dut (.clk(clk), .rst(rst), .bus(bus_if));

    int total = 0;
    int bad   = 0;
    logic [OF*RW-1:0] exp_rows [BS];
    int exp_sat  = 0;
    bit exp_drop = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int floor_div(input int v);
        int d;
        d = 1 << SH;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic void model_row(input logic [OF*OW-1:0] din, output logic [OF*RW-1:0] r,
                                      output int nsat);
        int hi, lo;
        hi = (1 << (RW - 1)) - 1;
        lo = -(1 << (RW - 1));
        nsat = 0;
        r = '0;
        for (int i = 0; i < OF; i++) begin
            logic [OW-1:0] e;
            int s;
            e = din[i*OW +: OW];
            s = floor_div(int'($signed(e)));
`ifdef MATRIX_OUT_RELU_EN
            if (s < 0) s = 0;
`endif
            if (s > hi) begin s = hi; nsat++; end
            else if (s < lo) begin s = lo; nsat++; end
            r[i*RW +: RW] = RW'(s);
        end
    endfunction

    function automatic logic [OF*OW-1:0] gen_row(input int mode);
        logic [OF*OW-1:0] d;
        d = '0;
        case (mode)
            0: d[OW-1:0] = 16'h0123;
            1: d[4*OW-1:0] = {16'hFFF0, 16'hFFFF, 16'h8000, 16'h0800};
            3: for (int i = 0; i < OF; i++) d[i*OW +: OW] = 16'h7FFF;
            default: begin
                for (int i = 0; i < OF; i++) begin
                    if ($urandom_range(0, 1) == 1) d[i*OW +: OW] = OW'($urandom);
                    else d[i*OW +: OW] = OW'(int'($urandom_range(0, 4000)) - 2000);
                end
            end
        endcase
        return d;
    endfunction

    function automatic q_t rand_order();
        int p [BS];
        q_t q;
        for (int i = 0; i < BS; i++) p[i] = i;
        for (int i = BS - 1; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
        for (int i = 0; i < BS; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) q.push_back(p[int'($urandom_range(0, i - 1))]);
            q.push_back(p[i]);
        end
        return q;
    endfunction

    task automatic fill(input q_t addrs, input int mode);
        bit seen [BS];
        int cnt;
        cnt = 0;
        for (int k = 0; k < BS; k++) seen[k] = 1'b0;
        foreach (addrs[k]) begin
            logic [OF*OW-1:0] d;
            logic [OF*RW-1:0] r;
            int n;
            if (cnt < BS) begin
                d = gen_row(mode);
                bus_if.outputWrEn = 1'b1;
                bus_if.outputAddr = 3'(addrs[k]);
                bus_if.outputData = d;
                @(posedge clk); #1;
                bus_if.outputWrEn = 1'b0;
                model_row(d, r, n);
                exp_rows[addrs[k]] = r;
                exp_sat = (exp_sat + n > 65535) ? 65535 : exp_sat + n;
                if (!seen[addrs[k]]) begin
                    seen[addrs[k]] = 1'b1;
                    cnt++;
                end
                check_eq("fill_sat", 64'(bus_if.satCount), 64'(exp_sat));
                check_eq("fill_valid", 64'(bus_if.resultValid), 64'(cnt == BS));
                check_eq("fill_bdone", 64'(bus_if.batchDone), 64'd0);
            end
        end
    endtask

    // mode 0: ready high; 1: random ready; 2: toggling ready with a 3-cycle stall on row 2.
    task automatic drain(input int mode, input bit drops, input int stop_after);
        int idx, stall, cyc;
        bit tog, rdy, held;
        logic [OF*RW-1:0] pd;
        logic [2:0] pa;
        idx = 0; stall = 0; cyc = 0; tog = 1'b1; held = 1'b0; pd = '0; pa = '0;
        while (idx < stop_after && cyc < 200) begin
            cyc++;
            check_eq("drn_valid", 64'(bus_if.resultValid), 64'd1);
            check_eq("drn_addr", 64'(bus_if.resultAddr), 64'(idx));
            check_eq("drn_data", 64'(bus_if.resultData), 64'(exp_rows[idx]));
            check_eq("drn_bdone", 64'(bus_if.batchDone), 64'd0);
            if (held) begin
                check_eq("hold_addr", 64'(bus_if.resultAddr), 64'(pa));
                check_eq("hold_data", 64'(bus_if.resultData), 64'(pd));
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 1) == 1);
                default: begin
                    if (idx == 2 && stall < 3) begin
                        rdy = 1'b0;
                        stall++;
                    end else begin
                        rdy = tog;
                        tog = !tog;
                    end
                end
            endcase
            bus_if.resultReady = rdy;
            if (drops && ($urandom_range(0, 3) == 0 || (rdy && idx == BS - 1))) begin
                bus_if.outputWrEn = 1'b1;
                bus_if.outputAddr = 3'($urandom_range(0, BS - 1));
                bus_if.outputData = gen_row(2);
                exp_drop = 1'b1;
            end
            held = !rdy;
            pa = bus_if.resultAddr;
            pd = bus_if.resultData;
            @(posedge clk); #1;
            bus_if.outputWrEn = 1'b0;
            if (rdy) idx++;
        end
        bus_if.resultReady = 1'b0;
        check_eq("drn_count", 64'(idx), 64'(stop_after));
        check_eq("drn_drop", 64'(bus_if.dropErr), 64'(exp_drop));
        if (idx == BS) begin
            check_eq("done_pulse", 64'(bus_if.batchDone), 64'd1);
            check_eq("done_valid", 64'(bus_if.resultValid), 64'd0);
            @(posedge clk); #1;
            check_eq("done_clear", 64'(bus_if.batchDone), 64'd0);
            check_eq("idle_valid", 64'(bus_if.resultValid), 64'd0);
        end
    endtask

    initial begin
        q_t seq;
        seq = {0, 1, 2, 3, 4, 5, 6, 7};
        rst = 1'b1;
        bus_if.outputWrEn  = 1'b0;
        bus_if.outputAddr  = '0;
        bus_if.outputData  = '0;
        bus_if.resultReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(bus_if.resultValid), 64'd0);
        check_eq("rst_data", 64'(bus_if.resultData), 64'd0);
        check_eq("rst_addr", 64'(bus_if.resultAddr), 64'd0);
        check_eq("rst_bdone", 64'(bus_if.batchDone), 64'd0);
        check_eq("rst_drop", 64'(bus_if.dropErr), 64'd0);
        check_eq("rst_sat", 64'(bus_if.satCount), 64'd0);
        rst = 1'b0;

        fill(seq, 0);
        check_eq("single_e0", 64'(bus_if.resultData[RW-1:0]), 64'h12);
        check_eq("single_sat", 64'(bus_if.satCount), 64'd0);
        drain(0, 1'b0, BS);

        fill(seq, 1);
`ifdef MATRIX_OUT_RELU_EN
        check_eq("sat_pattern", 64'(bus_if.resultData[4*RW-1:0]), 64'h0000007F);
        check_eq("sat_count", 64'(bus_if.satCount), 64'd8);
`else
        check_eq("sat_pattern", 64'(bus_if.resultData[4*RW-1:0]), 64'hFFFF807F);
        check_eq("sat_count", 64'(bus_if.satCount), 64'd16);
`endif
        drain(1, 1'b0, BS);

        fill({7, 3, 3, 0, 1, 2, 4, 5, 6}, 2);
        drain(2, 1'b0, BS);

        fill(rand_order(), 2);
        drain(1, 1'b1, BS);
        check_eq("drop_set", 64'(bus_if.dropErr), 64'd1);
        fill(rand_order(), 2);
        drain(2, 1'b0, BS);
        check_eq("drop_sticky", 64'(bus_if.dropErr), 64'd1);

        repeat (6) begin
            fill(rand_order(), 2);
            drain(int'($urandom_range(0, 2)), ($urandom_range(0, 1) == 1), BS);
        end

        fill(rand_order(), 2);
        drain(0, 1'b1, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_sat  = 0;
        exp_drop = 1'b0;
        check_eq("mid_rst_valid", 64'(bus_if.resultValid), 64'd0);
        check_eq("mid_rst_data", 64'(bus_if.resultData), 64'd0);
        check_eq("mid_rst_sat", 64'(bus_if.satCount), 64'd0);
        check_eq("mid_rst_drop", 64'(bus_if.dropErr), 64'd0);
        fill(seq, 2);
        drain(1, 1'b0, BS);

        repeat (1030) begin
            fill(seq, 3);
            drain(0, 1'b0, BS);
        end
        check_eq("sat_clamp", 64'(bus_if.satCount), 64'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
